// File: rtl/count_timer_pkg.sv
// Shared definitions for the count_timer timebase: operating mode encodings.
package count_timer_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_UPDOWN   = 2'b11
  } mode_e;

endpackage

// File: rtl/count_prescaler.sv
// Clock prescaler: tick is high on every (prescale+1)-th enabled clock.
module count_prescaler #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          clear,
  input  logic [PW-1:0] prescale,
  output logic          tick
);

  logic [PW-1:0] presc_cnt;

  assign tick = enable && (presc_cnt == prescale);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_cnt <= '0;
    end else if (clear || tick) begin
      presc_cnt <= '0;
    end else if (enable) begin
      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_timer.sv
// Up/up-down timer with prescaler, NCMP compare channels and FREE/PERIODIC/ONESHOT/UPDOWN modes.
module count_timer
  import count_timer_pkg::*;
#(
  parameter int unsigned BIN  = 32,
  parameter int unsigned NCMP = 2,
  parameter int unsigned PW   = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sw_clear,
  input  logic                load,
  input  logic [BIN-1:0]      load_value,
  input  logic [1:0]          mode,
  input  logic [PW-1:0]       prescale,
  input  logic [NCMP*BIN-1:0] match_value,
  output logic [BIN-1:0]      oCounter,
  output logic [NCMP-1:0]     match,
  output logic                ovf,
  output logic                running,
  output logic                dir
);

  mode_e           cur_mode;
  logic            done;
  logic            tick;
  logic [BIN-1:0]  mv0;
  logic [BIN-1:0]  up_step;
  logic [BIN-1:0]  dn_step;
  logic [BIN-1:0]  next_count;
  logic            next_dir;
  logic            next_done;
  logic            next_ovf;
  logic [NCMP-1:0] hit;

  assign cur_mode = mode_e'(mode);
  assign mv0      = match_value[BIN-1:0];
  assign up_step  = oCounter + 1'b1;
  assign dn_step  = oCounter - 1'b1;
  assign running  = enable && !done;

  count_prescaler #(.PW(PW)) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable && !done),
    .clear    (sw_clear || load),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    next_count = oCounter;
    next_dir   = dir;
    next_done  = done;
    next_ovf   = 1'b0;
    case (cur_mode)
      MODE_FREE: begin
        next_count = up_step;
        next_ovf   = &oCounter;
      end
      MODE_PERIODIC: begin
        if (oCounter == mv0) begin
          next_count = '0;
          next_ovf   = 1'b1;
        end else begin
          next_count = up_step;
          next_ovf   = &oCounter;
        end
      end
      MODE_ONESHOT: begin
        if (oCounter == mv0) begin
          next_done = 1'b1;
        end else begin
          next_count = up_step;
          next_done  = (up_step == mv0);
        end
      end
      MODE_UPDOWN: begin
        // Anything not strictly below the limit while rising is treated as the down leg,
        // which also covers mv0 being lowered under the count and the mv0==0 hold.
        if (dir && (oCounter < mv0)) begin
          next_count = up_step;
          if (up_step == mv0) next_dir = 1'b0;
        end else if (oCounter == '0) begin
          next_count = '0;
          next_dir   = 1'b1;
          next_ovf   = 1'b1;
        end else begin
          next_count = dn_step;
          next_dir   = (dn_step == '0);
          next_ovf   = (dn_step == '0);
        end
      end
    endcase
  end

  for (genvar i = 0; i < NCMP; i++) begin : g_cmp
    assign hit[i] = tick && (next_count == match_value[i*BIN +: BIN]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oCounter <= '0;
      match    <= '0;
      ovf      <= 1'b0;
      dir      <= 1'b1;
      done     <= 1'b0;
    end else if (sw_clear || load) begin
      oCounter <= sw_clear ? '0 : load_value;
      match    <= '0;
      ovf      <= 1'b0;
      dir      <= 1'b1;
      done     <= 1'b0;
    end else begin
      match <= hit;
      ovf   <= tick && next_ovf;
      if (tick) begin
        oCounter <= next_count;
        dir      <= next_dir;
        done     <= next_done;
      end
    end
  end

endmodule

// File: tb/tb_count_timer.sv
// Scoreboard bench for count_timer: expected match/ovf pulses are queued, a monitor pops on each pulse.
module tb_count_timer;
  import count_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sw_clear;
  logic        load;
  logic [31:0] load_value;
  logic [1:0]  mode;
  logic [7:0]  prescale;
  logic [63:0] match_value;
  logic [31:0] oCounter;
  logic [1:0]  match;
  logic        ovf;
  logic        running;
  logic        dir;

  typedef struct packed {
    logic [1:0]  m;
    logic        o;
    logic [31:0] c;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  always #5 clk = ~clk;

  count_timer #(.BIN(32), .NCMP(2), .PW(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sw_clear    (sw_clear),
    .load        (load),
    .load_value  (load_value),
    .mode        (mode),
    .prescale    (prescale),
    .match_value (match_value),
    .oCounter    (oCounter),
    .match       (match),
    .ovf         (ovf),
    .running     (running),
    .dir         (dir)
  );

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (match !== 2'b00 || ovf !== 1'b0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got match=%b ovf=%b count=%h, required no pulse",
                 match, ovf, oCounter);
      end else begin
        mon_e = exp_q.pop_front();
        if ({match, ovf, oCounter} !== mon_e) begin
          n_bad++;
          $display("FAIL pulse: got match=%b ovf=%b count=%h, required match=%b ovf=%b count=%h",
                   match, ovf, oCounter, mon_e.m, mon_e.o, mon_e.c);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [1:0] m, input logic o, input logic [31:0] c);
    exp_q.push_back({m, o, c});
  endtask

  task automatic clear_all();
    enable   = 1'b0;
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0;
  endtask

  task automatic set_cfg(input mode_e md, input logic [7:0] ps,
                         input logic [31:0] m0, input logic [31:0] m1);
    mode        = md;
    prescale    = ps;
    match_value = {m1, m0};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    sw_clear   = 1'b0;
    load       = 1'b0;
    load_value = '0;
    set_cfg(MODE_FREE, 8'd0, 32'd25, 32'd10);
    step(2);
    chk("rst_count", oCounter, 32'd0);
    chk("rst_match", match, 32'd0);
    chk("rst_ovf", ovf, 32'd0);
    chk("rst_dir", dir, 32'd1);
    chk("rst_running", running, 32'd0);
    reset_n = 1'b1;
    step(1);

    // FREE: channel 1 at 10, channel 0 at 25, no ovf
    expect_ev(2'b10, 1'b0, 32'd10);
    expect_ev(2'b01, 1'b0, 32'd25);
    enable = 1'b1;
    step(30);
    chk("free_count", oCounter, 32'd30);
    clear_all();
    chk("free_pending", 32'(exp_q.size()), 32'd0);

    // PERIODIC, prescale 3, period 5 ticks of 4 clocks
    set_cfg(MODE_PERIODIC, 8'd3, 32'd4, 32'd2);
    repeat (2) begin
      expect_ev(2'b10, 1'b0, 32'd2);
      expect_ev(2'b01, 1'b0, 32'd4);
      expect_ev(2'b00, 1'b1, 32'd0);
    end
    enable = 1'b1;
    step(6);
    chk("per_first_tick", oCounter, 32'd1);
    step(34);
    chk("per_count", oCounter, 32'd0);
    clear_all();
    chk("per_pending", 32'(exp_q.size()), 32'd0);

    // PERIODIC with mv0 = 0
    set_cfg(MODE_PERIODIC, 8'd0, 32'd0, 32'd7);
    repeat (3) expect_ev(2'b01, 1'b1, 32'd0);
    enable = 1'b1;
    step(3);
    chk("per0_count", oCounter, 32'd0);
    clear_all();
    chk("per0_pending", 32'(exp_q.size()), 32'd0);

    // ONESHOT stops at 5, load 0 re-arms
    set_cfg(MODE_ONESHOT, 8'd0, 32'd5, 32'd200);
    expect_ev(2'b01, 1'b0, 32'd5);
    enable = 1'b1;
    step(5);
    chk("os_count", oCounter, 32'd5);
    chk("os_running", running, 32'd0);
    step(100);
    chk("os_hold", oCounter, 32'd5);
    chk("os_hold_running", running, 32'd0);
    chk("os_pending", 32'(exp_q.size()), 32'd0);
    load_value = 32'd0;
    load       = 1'b1;
    step(1);
    load = 1'b0;
    chk("os_load", oCounter, 32'd0);
    chk("os_rearm_running", running, 32'd1);
    expect_ev(2'b01, 1'b0, 32'd5);
    step(5);
    chk("os_count2", oCounter, 32'd5);
    chk("os_running2", running, 32'd0);
    clear_all();
    chk("os_pending2", 32'(exp_q.size()), 32'd0);

    // UPDOWN, mv0 = 3: 1,2,3,2,1,0 repeating
    set_cfg(MODE_UPDOWN, 8'd0, 32'd3, 32'd1);
    repeat (2) begin
      expect_ev(2'b10, 1'b0, 32'd1);
      expect_ev(2'b01, 1'b0, 32'd3);
      expect_ev(2'b10, 1'b0, 32'd1);
      expect_ev(2'b00, 1'b1, 32'd0);
    end
    enable = 1'b1;
    step(3);
    chk("ud_peak", oCounter, 32'd3);
    chk("ud_dir_down", dir, 32'd0);
    step(3);
    chk("ud_floor", oCounter, 32'd0);
    chk("ud_dir_up", dir, 32'd1);
    step(6);
    chk("ud_floor2", oCounter, 32'd0);
    clear_all();
    chk("ud_pending", 32'(exp_q.size()), 32'd0);

    // FREE wrap after load, then load+sw_clear together
    set_cfg(MODE_FREE, 8'd0, 32'd25, 32'd10);
    load_value = 32'hFFFF_FFFE;
    load       = 1'b1;
    enable     = 1'b1;
    step(1);
    load = 1'b0;
    chk("wrap_load", oCounter, 32'hFFFF_FFFE);
    expect_ev(2'b00, 1'b1, 32'd0);
    step(1);
    chk("wrap_max", oCounter, 32'hFFFF_FFFF);
    step(1);
    chk("wrap_zero", oCounter, 32'd0);
    load_value = 32'h1234;
    load       = 1'b1;
    sw_clear   = 1'b1;
    step(1);
    load     = 1'b0;
    sw_clear = 1'b0;
    enable   = 1'b0;
    chk("clear_beats_load", oCounter, 32'd0);
    chk("wrap_pending", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-count while counting down
    clear_all();
    set_cfg(MODE_UPDOWN, 8'd0, 32'd3, 32'd1);
    expect_ev(2'b10, 1'b0, 32'd1);
    expect_ev(2'b01, 1'b0, 32'd3);
    enable = 1'b1;
    step(4);
    chk("pre_rst_count", oCounter, 32'd2);
    chk("pre_rst_dir", dir, 32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_count", oCounter, 32'd0);
    chk("async_rst_dir", dir, 32'd1);
    chk("async_rst_match", match, 32'd0);
    chk("async_rst_ovf", ovf, 32'd0);
    step(1);
    reset_n = 1'b1;
    enable  = 1'b0;
    chk("rst_pending", 32'(exp_q.size()), 32'd0);

    // enable low freezes count and suppresses pulses
    clear_all();
    set_cfg(MODE_FREE, 8'd0, 32'd25, 32'd5);
    expect_ev(2'b10, 1'b0, 32'd5);
    enable = 1'b1;
    step(5);
    chk("frz_count", oCounter, 32'd5);
    enable = 1'b0;
    repeat (10) begin
      step(1);
      chk("frz_hold", oCounter, 32'd5);
      chk("frz_match", match, 32'd0);
      chk("frz_ovf", ovf, 32'd0);
    end
    enable = 1'b1;
    step(1);
    chk("frz_resume", oCounter, 32'd6);
    clear_all();
    chk("frz_pending", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
